aes_encryptor_ser_buffer: RTL

Parametrised, single-clock output buffer between the AES encryption core and the OFDM serial interface. It accepts complete cipher-text state blocks (NO_ROWS x NO_COLS bytes) through a valid/ready handshake and holds them in a block FIFO. It then serialises each block onto an OUT_WIDTH-bit output stream using a valid/ready handshake, with selectable byte order and bit order. Block FIFO occupancy and a sent-block counter are exported for status registers.

---
 rtl/aes_encryptor_ser_buffer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/aes_encryptor_ser_buffer.sv
// Output buffer between the AES core and the OFDM serial port: a FIFO of whole
// cipher-text state blocks followed by a serialiser with selectable byte and bit order.
module aes_encryptor_ser_buffer #(
  parameter int NO_ROWS      = 4,
  parameter int NO_COLS      = 4,
  parameter int DEPTH_BLOCKS = 16,
  parameter int OUT_WIDTH    = 8,
  parameter int LEVEL_W      = $clog2(DEPTH_BLOCKS + 1)
) (
  input  logic                                   aes_clk,
  input  logic                                   reset,
  input  logic                                   flush,
  input  logic                                   cipher_txt_vld,
  output logic                                   cipher_txt_rdy,
  input  logic [NO_ROWS-1:0][NO_COLS-1:0][7:0]   p_cipher_txt,
  input  logic                                   col_major,
  input  logic                                   msb_first,
  output logic                                   ofdm_sdata_vld,
  input  logic                                   ofdm_sdata_rdy,
  output logic [OUT_WIDTH-1:0]                   ofdm_sdata,
  output logic [LEVEL_W-1:0]                     fill_level,
  output logic                                   buf_full,
  output logic                                   buf_empty,
  output logic [15:0]                            blk_sent
);

  localparam int NB    = NO_ROWS * NO_COLS;
  localparam int BLK_W = 8 * NB;
  localparam int BEATS = BLK_W / OUT_WIDTH;
  localparam int CNT_W = $clog2(BEATS);
  localparam int BPB   = 8 / OUT_WIDTH;
  localparam int AW    = $clog2(DEPTH_BLOCKS);
  localparam int PTR_W = AW + 1;

  localparam logic [CNT_W-1:0]   LAST_BEAT  = CNT_W'(BEATS - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(DEPTH_BLOCKS);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLK_W-1:0]   sr_q, sr_d;
  logic               msb_q, msb_d;
  logic [15:0]        blk_sent_q, blk_sent_d;
  logic [BLK_W-1:0]   mem_q [DEPTH_BLOCKS];

  logic [BLK_W-1:0]   lin_blk;
  logic [7:0]         beat_byte;
  logic               ptr_full, ptr_empty;
  logic               wr_en, beat_acc, last_acc, load;
  int                 sub_idx;

  assign ptr_empty = (wr_ptr_q == rd_ptr_q);
  assign ptr_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign cipher_txt_rdy = !ptr_full && !reset;
  assign wr_en          = cipher_txt_vld && cipher_txt_rdy && !flush;
  assign beat_acc       = (state_q == SHIFT) && ofdm_sdata_rdy;
  assign last_acc       = beat_acc && (cnt_q == LAST_BEAT);
  assign load           = ((state_q == IDLE) || last_acc) && !ptr_empty && !flush;
  assign sub_idx        = int'(cnt_q) % BPB;

  assign fill_level = fill_q;
  assign buf_full   = (fill_q == LEVEL_FULL);
  assign buf_empty  = (fill_q == '0);
  assign blk_sent   = blk_sent_q;

  // Byte k of the stored block is the k-th byte sent.
  // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    lin_blk = '0;
    for (int k = 0; k < NB; k++) begin
      if (col_major) lin_blk[8*k +: 8] = p_cipher_txt[k % NO_ROWS][k / NO_ROWS];
      else           lin_blk[8*k +: 8] = p_cipher_txt[k / NO_COLS][k % NO_COLS];
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush)         state_d = IDLE;
    else if (load)     state_d = SHIFT;
    else if (last_acc) state_d = IDLE;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    msb_d      = msb_q;
    blk_sent_d = blk_sent_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;

    if (load) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      sr_d     = mem_q[rd_ptr_q[AW-1:0]];
      cnt_d    = '0;
      msb_d    = msb_first;
    end else if (beat_acc) begin
      cnt_d = last_acc ? '0 : cnt_q + 1'b1;
      if (sub_idx == BPB - 1) sr_d = sr_q >> 8;
    end

    case ({wr_en, load})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase

    if (last_acc && !flush) blk_sent_d = blk_sent_q + 1'b1;

    // Flush discards queued and in-flight blocks; the sent count is history and survives.
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      fill_d   = '0;
      cnt_d    = '0;
    end
  end

  always_comb begin
    ofdm_sdata_vld = (state_q == SHIFT);
    beat_byte      = '0;
    if (state_q == SHIFT) begin
      if (msb_q) beat_byte = sr_q[7:0] >> (8 - OUT_WIDTH * (sub_idx + 1));
      else       beat_byte = sr_q[7:0] >> (OUT_WIDTH * sub_idx);
    end
    ofdm_sdata = beat_byte[OUT_WIDTH-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aes_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      cnt_q      <= '0;
      sr_q       <= '0;
      msb_q      <= 1'b0;
      blk_sent_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      msb_q      <= msb_d;
      blk_sent_q <= blk_sent_d;
    end
  end

  // NOTE: the block store has no reset; stale contents are unreachable once pointers are cleared.
  always_ff @(posedge aes_clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= lin_blk;
  end

endmodule
